stage_id: RTL and testbench

Instruction-decode stage of the five-stage RV32I pipeline, between IF and EX. It decodes a 32-bit instruction and drives combinational read addresses to the register file. It forms ALU operands, jump/branch-target operands and the writeback control from the register read data, immediates and the instruction address. The result is registered into the ID/EX pipeline register.

---
 rtl/stage_id.sv | 195 +++++++++++++++++++
 tb/tb_stage_id.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id.sv
// RV32I instruction-decode stage: combinational register-file read addresses,
// operand/immediate selection, and the ID/EX pipeline register.
module stage_id (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_inst_addr,
    input  logic [31:0] i_reg1_data,
    input  logic [31:0] i_reg2_data,
    output logic [4:0]  o_reg1_rd_addr,
    output logic [4:0]  o_reg2_rd_addr,
    output logic        o_reg_we,
    output logic [4:0]  o_reg_wr_addr,
    output logic [31:0] o_op1,
    output logic [31:0] o_op2,
    output logic [31:0] o_op1_jump,
    output logic [31:0] o_op2_jump,
    output logic [31:0] o_store_data,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_addr
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign rd     = i_inst[11:7];

    assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_u = {i_inst[31:12], 12'b0};
    assign imm_j = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    logic        rs1_used, rs2_used;
    logic        reg_we_d, reg_we_q;
    logic [4:0]  reg_wr_addr_d, reg_wr_addr_q;
    logic [31:0] op1_d, op1_q;
    logic [31:0] op2_d, op2_q;
    logic [31:0] op1_jump_d, op1_jump_q;
    logic [31:0] op2_jump_d, op2_jump_q;
    logic [31:0] store_data_d, store_data_q;
    logic [31:0] inst_d, inst_q;
    logic [31:0] inst_addr_d, inst_addr_q;

    always_comb begin
        rs1_used      = 1'b0;
        rs2_used      = 1'b0;
        reg_we_d      = 1'b0;
        reg_wr_addr_d = 5'd0;
        op1_d         = 32'd0;
        op2_d         = 32'd0;
        op1_jump_d    = 32'd0;
        op2_jump_d    = 32'd0;
        store_data_d  = 32'd0;
        inst_d        = i_inst;
        inst_addr_d   = i_inst_addr;

        case (opcode)
            OP_R: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                op1_d    = i_reg1_data;
                op2_d    = i_reg2_data;
                reg_we_d = 1'b1;
            end
            OP_I_ALU: begin
                rs1_used = 1'b1;
                op1_d    = i_reg1_data;
                // Shift-immediates carry funct7 in the upper immediate bits; only shamt is the operand.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    op2_d = {27'd0, i_inst[24:20]};
                end else begin
                    op2_d = imm_i;
                end
                reg_we_d = 1'b1;
            end
            OP_LOAD: begin
                rs1_used = 1'b1;
                op1_d    = i_reg1_data;
                op2_d    = imm_i;
                reg_we_d = 1'b1;
            end
            OP_STORE: begin
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
                op1_d        = i_reg1_data;
                op2_d        = imm_s;
                store_data_d = i_reg2_data;
            end
            OP_BRANCH: begin
                rs1_used   = 1'b1;
                rs2_used   = 1'b1;
                op1_d      = i_reg1_data;
                op2_d      = i_reg2_data;
                op1_jump_d = i_inst_addr;
                op2_jump_d = imm_b;
            end
            OP_LUI: begin
                op1_d    = imm_u;
                reg_we_d = 1'b1;
            end
            OP_AUIPC: begin
                op1_d    = i_inst_addr;
                op2_d    = imm_u;
                reg_we_d = 1'b1;
            end
            OP_JAL: begin
                op1_d      = i_inst_addr;
                op2_d      = 32'd4;
                op1_jump_d = i_inst_addr;
                op2_jump_d = imm_j;
                reg_we_d   = 1'b1;
            end
            OP_JALR: begin
                rs1_used   = 1'b1;
                op1_d      = i_inst_addr;
                op2_d      = 32'd4;
                op1_jump_d = i_reg1_data;
                op2_jump_d = imm_i;
                reg_we_d   = 1'b1;
            end
            default: ;
        endcase

        if (rd == 5'd0) begin
            reg_we_d = 1'b0;
        end
        reg_wr_addr_d = reg_we_d ? rd : 5'd0;

        if (i_flush) begin
            reg_we_d      = 1'b0;
            reg_wr_addr_d = 5'd0;
            op1_d         = 32'd0;
            op2_d         = 32'd0;
            op1_jump_d    = 32'd0;
            op2_jump_d    = 32'd0;
            store_data_d  = 32'd0;
            inst_d        = 32'd0;
            inst_addr_d   = 32'd0;
        end
    end

    assign o_reg1_rd_addr = rs1_used ? i_inst[19:15] : 5'd0;
    assign o_reg2_rd_addr = rs2_used ? i_inst[24:20] : 5'd0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            reg_we_q      <= 1'b0;
            reg_wr_addr_q <= 5'd0;
            op1_q         <= 32'd0;
            op2_q         <= 32'd0;
            op1_jump_q    <= 32'd0;
            op2_jump_q    <= 32'd0;
            store_data_q  <= 32'd0;
            inst_q        <= 32'd0;
            inst_addr_q   <= 32'd0;
        end else begin
            reg_we_q      <= reg_we_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            op1_jump_q    <= op1_jump_d;
            op2_jump_q    <= op2_jump_d;
            store_data_q  <= store_data_d;
            inst_q        <= inst_d;
            inst_addr_q   <= inst_addr_d;
        end
    end

    assign o_reg_we      = reg_we_q;
    assign o_reg_wr_addr = reg_wr_addr_q;
    assign o_op1         = op1_q;
    assign o_op2         = op2_q;
    assign o_op1_jump    = op1_jump_q;
    assign o_op2_jump    = op2_jump_q;
    assign o_store_data  = store_data_q;
    assign o_inst        = inst_q;
    assign o_inst_addr   = inst_addr_q;

endmodule

// File: tb/tb_stage_id.sv
// Self-checking bench for stage_id: directed decode cases, reset/flush bubbles,
// and a randomized stream checked against an independent decode model.
module tb_stage_id;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] j1;
        logic [31:0] j2;
        logic [31:0] sd;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_inst = 32'd0;
    logic [31:0] i_inst_addr = 32'd0;
    logic [31:0] i_reg1_data;
    logic [31:0] i_reg2_data;
    logic [4:0]  o_reg1_rd_addr, o_reg2_rd_addr;
    logic        o_reg_we;
    logic [4:0]  o_reg_wr_addr;
    logic [31:0] o_op1, o_op2, o_op1_jump, o_op2_jump, o_store_data, o_inst, o_inst_addr;

    logic rf_mode = 1'b0;
    exp_t obs;
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    stage_id dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_flush        (i_flush),
        .i_inst         (i_inst),
        .i_inst_addr    (i_inst_addr),
        .i_reg1_data    (i_reg1_data),
        .i_reg2_data    (i_reg2_data),
        .o_reg1_rd_addr (o_reg1_rd_addr),
        .o_reg2_rd_addr (o_reg2_rd_addr),
        .o_reg_we       (o_reg_we),
        .o_reg_wr_addr  (o_reg_wr_addr),
        .o_op1          (o_op1),
        .o_op2          (o_op2),
        .o_op1_jump     (o_op1_jump),
        .o_op2_jump     (o_op2_jump),
        .o_store_data   (o_store_data),
        .o_inst         (o_inst),
        .o_inst_addr    (o_inst_addr)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] rfv(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        return 32'(a) * 32'h0808_0101 + 32'h5A5A_0000;
    endfunction

    always_comb begin
        i_reg1_data = rf_mode ? rfv(o_reg1_rd_addr) : 32'h0000_FFFF;
        i_reg2_data = rf_mode ? rfv(o_reg2_rd_addr) : 32'h0000_FFFF;
    end

    assign obs = {o_reg_we, o_reg_wr_addr, o_op1, o_op2, o_op1_jump, o_op2_jump,
                  o_store_data, o_inst, o_inst_addr};

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic exp_t mk(input logic we, input logic [4:0] wa, input logic [31:0] op1,
                                input logic [31:0] op2, input logic [31:0] j1,
                                input logic [31:0] j2, input logic [31:0] sd,
                                input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e = {we, wa, op1, op2, j1, j2, sd, inst, pc};
        return e;
    endfunction

    // Reference decode; r1/r2 are the values the register file holds for rs1/rs2.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic flush);
        exp_t e;
        logic [31:0] ii, is, ib, iu, ij;
        ii = {{20{inst[31]}}, inst[31:20]};
        is = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ib = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        iu = {inst[31:12], 12'h000};
        ij = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        e = '0;
        e.inst = inst;
        e.pc = pc;
        case (inst[6:0])
            7'h33: begin e.op1 = r1; e.op2 = r2; e.we = 1; end
            7'h13: begin
                e.op1 = r1; e.we = 1;
                e.op2 = (inst[14:12] == 3'd1 || inst[14:12] == 3'd5) ? 32'(inst[24:20]) : ii;
            end
            7'h03: begin e.op1 = r1; e.op2 = ii; e.we = 1; end
            7'h23: begin e.op1 = r1; e.op2 = is; e.sd = r2; end
            7'h63: begin e.op1 = r1; e.op2 = r2; e.j1 = pc; e.j2 = ib; end
            7'h37: begin e.op1 = iu; e.we = 1; end
            7'h17: begin e.op1 = pc; e.op2 = iu; e.we = 1; end
            7'h6F: begin e.op1 = pc; e.op2 = 4; e.j1 = pc; e.j2 = ij; e.we = 1; end
            7'h67: begin e.op1 = pc; e.op2 = 4; e.j1 = r1; e.j2 = ii; e.we = 1; end
            default: ;
        endcase
        if (inst[11:7] == 5'd0) e.we = 0;
        e.wa = e.we ? inst[11:7] : 5'd0;
        if (flush) e = '0;
        return e;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic flush,
                         input exp_t e);
        @(negedge i_clk);
        i_inst = inst;
        i_inst_addr = pc;
        i_flush = flush;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        exp_t e;
        i_rst = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_init got=%h want=0", obs);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    task automatic test_directed;
        localparam int N = 13;
        logic [31:0] insts[N];
        logic [31:0] pcs[N];
        exp_t exps[N];
        exp_t e;
        logic [31:0] x;
        logic [31:0] f;
        x = 32'h0000_FFFF;
        insts[0]  = enc(7'd0, 5'd4, 5'd2, 3'd0, 5'd1, 7'b0010011);
        exps[0]   = mk(1, 1, x, 4, 0, 0, 0, insts[0], 0);
        insts[1]  = enc(7'd0, 5'd4, 5'd2, 3'd7, 5'd1, 7'b0110011);
        exps[1]   = mk(1, 1, x, x, 0, 0, 0, insts[1], 0);
        insts[2]  = enc(7'd0, 5'd4, 5'd2, 3'd2, 5'd1, 7'b0100011);
        exps[2]   = mk(0, 0, x, 1, 0, 0, x, insts[2], 0);
        insts[3]  = enc(7'd0, 5'd4, 5'd2, 3'd1, 5'd1, 7'b1100011);
        exps[3]   = mk(0, 0, x, x, 0, 32'h800, 0, insts[3], 0);
        insts[4]  = enc(7'd0, 5'd4, 5'd2, 3'd1, 5'd1, 7'b0110111);
        exps[4]   = mk(1, 1, 32'h0041_1000, 0, 0, 0, 0, insts[4], 0);
        insts[5]  = enc(7'd0, 5'd4, 5'd2, 3'd1, 5'd1, 7'b0010111);
        exps[5]   = mk(1, 1, 0, 32'h0041_1000, 0, 0, 0, insts[5], 0);
        insts[6]  = enc(7'd0, 5'd4, 5'd2, 3'd1, 5'd1, 7'b1101111);
        exps[6]   = mk(1, 1, 0, 4, 0, 32'h0001_1004, 0, insts[6], 0);
        insts[7]  = enc(7'd0, 5'd4, 5'd2, 3'd0, 5'd1, 7'b1100111);
        exps[7]   = mk(1, 1, 0, 4, x, 4, 0, insts[7], 0);
        insts[8]  = enc(7'd0, 5'd4, 5'd2, 3'd0, 5'd0, 7'b1100111);
        exps[8]   = mk(0, 0, 0, 4, x, 4, 0, insts[8], 0);
        insts[9]  = enc(7'b0100000, 5'd5, 5'd2, 3'd5, 5'd3, 7'b0010011);
        exps[9]   = mk(1, 3, x, 5, 0, 0, 0, insts[9], 0);
        insts[10] = 32'd0;
        exps[10]  = '0;
        insts[11] = enc(7'd0, 5'd4, 5'd2, 3'd1, 5'd1, 7'b0010111);
        exps[11]  = mk(1, 1, 32'h100, 32'h0041_1000, 0, 0, 0, insts[11], 32'h100);
        // Negative immediate exercises sign extension from bit 31.
        insts[12] = enc(7'h7F, 5'h1F, 5'd2, 3'd0, 5'd1, 7'b0000011);
        exps[12]  = mk(1, 1, x, 32'hFFFF_FFFF, 0, 0, 0, insts[12], 32'h40);
        for (int i = 0; i < N; i++) begin
            pcs[i] = exps[i].pc;
        end
        for (int i = 0; i < N; i++) begin
            drive(insts[i], pcs[i], 1'b0, exps[i]);
            if (i == 4) begin
                #1;
                vectors++;
                f = {22'd0, o_reg1_rd_addr, o_reg2_rd_addr};
                if (f !== 32'd0) begin
                    miscompares++;
                    $display("FAIL lui_rd_addr got=%h want=0", f);
                end
            end
            @(posedge i_clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL directed_%0d got=%h want=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_flush;
        exp_t e;
        logic [31:0] addi;
        addi = enc(7'd0, 5'd4, 5'd2, 3'd0, 5'd1, 7'b0010011);
        drive(addi, 32'h0000_0200, 1'b1, '0);
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL flush got=%h want=%h", obs, e);
        end
        drive(addi, 32'h0000_0204, 1'b0,
              mk(1, 1, 32'h0000_FFFF, 4, 0, 0, 0, addi, 32'h0000_0204));
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL after_flush got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        logic [31:0] addi;
        addi = enc(7'd0, 5'd4, 5'd2, 3'd0, 5'd1, 7'b0010011);
        e = mk(1, 1, 32'h0000_FFFF, 4, 0, 0, 0, addi, 32'h8);
        drive(addi, 32'h8, 1'b0, e);
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL pre_reset got=%h want=%h", obs, e);
        end
        #1;
        i_rst = 1'b0;
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h want=0", obs);
        end
        @(posedge i_clk);
        #1;
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_held got=%h want=0", obs);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL first_after_reset got=%h want=%h", obs, e);
        end
    endtask

    task automatic test_random;
        logic [6:0] ops[9];
        logic [31:0] inst, pc;
        logic [4:0] a1, a2;
        logic u1, u2;
        logic fl;
        exp_t e;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        rf_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            inst = {$urandom()} & 32'hFFFF_FF80;
            inst[6:0] = ops[$urandom_range(0, 8)];
            pc = {$urandom()} & 32'hFFFF_FFFC;
            fl = ($urandom_range(0, 9) == 0);
            u1 = (inst[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67});
            u2 = (inst[6:0] inside {7'h33, 7'h23, 7'h63});
            a1 = u1 ? inst[19:15] : 5'd0;
            a2 = u2 ? inst[24:20] : 5'd0;
            drive(inst, pc, fl, model(inst, pc, rfv(inst[19:15]), rfv(inst[24:20]), fl));
            #1;
            vectors++;
            if ({o_reg1_rd_addr, o_reg2_rd_addr} !== {a1, a2}) begin
                miscompares++;
                $display("FAIL rd_addr_%0d got=%h/%h want=%h/%h", n,
                         o_reg1_rd_addr, o_reg2_rd_addr, a1, a2);
            end
            @(posedge i_clk);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL random_%0d inst=%h got=%h want=%h", n, inst, obs, e);
            end
        end
        rf_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
